// File: rtl/noc_vc_pipeline_link.sv
`default_nettype none
// ============================================================================
// noc_vc_pipeline_link: pipelined NoC flit/credit link with a per-VC
// upstream credit tracker. Optional NOC_LINK_CREDIT_CHECK_EN adds sticky
// protocol-error flags and saturating counters.
// Revision: 1.0
// ============================================================================
module noc_vc_pipeline_link #(
  parameter  int NUM_PIPELINE = 2,
  parameter  int NUM_VC       = 2,
  parameter  int FLIT_WIDTH   = 128,
  parameter  int DEST_WIDTH   = 8,
  parameter  int BUFFER_DEPTH = 4,
  localparam int VC_WIDTH     = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
  localparam int CNT_WIDTH    = $clog2(BUFFER_DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [FLIT_WIDTH-1:0]       data_in,
  input  logic [DEST_WIDTH-1:0]       dest_in,
  input  logic                        is_tail_in,
  input  logic [VC_WIDTH-1:0]         vc_in,
  input  logic                        send_in,
  output logic [NUM_VC-1:0]           credit_out,
  output logic [FLIT_WIDTH-1:0]       data_out,
  output logic [DEST_WIDTH-1:0]       dest_out,
  output logic                        is_tail_out,
  output logic [VC_WIDTH-1:0]         vc_out,
  output logic                        send_out,
  input  logic [NUM_VC-1:0]           credit_in,
  output logic [NUM_VC*CNT_WIDTH-1:0] credit_count,
  output logic [NUM_VC-1:0]           credit_avail,
  output logic [NUM_VC-1:0]           credit_error
);

  localparam int                   PAYLOAD_W = FLIT_WIDTH + DEST_WIDTH + 1 + VC_WIDTH;
  localparam logic [CNT_WIDTH-1:0] C_DEPTH   = CNT_WIDTH'(BUFFER_DEPTH);
  localparam logic [CNT_WIDTH-1:0] C_ONE     = CNT_WIDTH'(1);

  logic [PAYLOAD_W-1:0] payload_in;
  logic [PAYLOAD_W-1:0] payload_out;

  assign payload_in = {data_in, dest_in, is_tail_in, vc_in};
  assign {data_out, dest_out, is_tail_out, vc_out} = payload_out;

  generate
    if (NUM_PIPELINE == 0) begin : g_bypass
      assign payload_out = payload_in;
      assign send_out    = send_in;
      assign credit_out  = credit_in;
    end else begin : g_pipe
      logic [PAYLOAD_W-1:0]    payload_q [NUM_PIPELINE];
      logic [NUM_PIPELINE-1:0] send_q;
      logic [NUM_VC-1:0]       credit_q  [NUM_PIPELINE];

      // Payload carries no reset so the stages can map onto hyper-registers.
      always_ff @(posedge clk) begin
        payload_q[0] <= payload_in;
        for (int i = 1; i < NUM_PIPELINE; i++) begin
          payload_q[i] <= payload_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          send_q <= '0;
          for (int i = 0; i < NUM_PIPELINE; i++) begin
            credit_q[i] <= '0;
          end
        end else begin
          send_q[0]   <= send_in;
          credit_q[0] <= credit_in;
          for (int i = 1; i < NUM_PIPELINE; i++) begin
            send_q[i]   <= send_q[i-1];
            credit_q[i] <= credit_q[i-1];
          end
        end
      end

      assign payload_out = payload_q[NUM_PIPELINE-1];
      assign send_out    = send_q[NUM_PIPELINE-1];
      assign credit_out  = credit_q[NUM_PIPELINE-1];
    end
  endgenerate

  logic [CNT_WIDTH-1:0] cnt_q [NUM_VC];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_VC];
  logic [NUM_VC-1:0]    dec_w;
  logic [NUM_VC-1:0]    inc_w;

`ifdef NOC_LINK_CREDIT_CHECK_EN
  logic [NUM_VC-1:0] under_w;
  logic [NUM_VC-1:0] over_w;
  logic [NUM_VC-1:0] err_q;
`endif

  // Out-of-range vc_in never matches any v, so the tracker ignores it.
  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      dec_w[v] = send_in && (int'(vc_in) == v);
      inc_w[v] = credit_out[v];
      cnt_d[v] = cnt_q[v];
`ifdef NOC_LINK_CREDIT_CHECK_EN
      under_w[v] = dec_w[v] && (cnt_q[v] == '0);
      over_w[v]  = inc_w[v] && (cnt_q[v] == C_DEPTH);
      if (inc_w[v] && !dec_w[v] && !over_w[v]) begin
        cnt_d[v] = cnt_q[v] + C_ONE;
      end else if (dec_w[v] && !inc_w[v] && !under_w[v]) begin
        cnt_d[v] = cnt_q[v] - C_ONE;
      end
`else
      if (inc_w[v] && !dec_w[v]) begin
        cnt_d[v] = cnt_q[v] + C_ONE;
      end else if (dec_w[v] && !inc_w[v]) begin
        cnt_d[v] = cnt_q[v] - C_ONE;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < NUM_VC; v++) begin
        cnt_q[v] <= C_DEPTH;
      end
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        cnt_q[v] <= cnt_d[v];
      end
    end
  end

`ifdef NOC_LINK_CREDIT_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= '0;
    end else begin
      err_q <= err_q | under_w | over_w;
    end
  end
  assign credit_error = err_q;
`else
  assign credit_error = '0;
`endif

  generate
    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc_out
      assign credit_count[v*CNT_WIDTH +: CNT_WIDTH] = cnt_q[v];
      assign credit_avail[v]                        = |cnt_q[v];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_noc_vc_pipeline_link.sv
`default_nettype none
// Bench for noc_vc_pipeline_link: a 3-stage instance driven from a vector
// table with a flit/credit scoreboard, plus a 0-stage pass-through instance.
module tb_noc_vc_pipeline_link;

  localparam int P  = 3;
  localparam int FW = 16;
  localparam int DW = 8;

`ifdef NOC_LINK_CREDIT_CHECK_EN
  localparam logic [2:0] E1_ERR = 3'd0;
  localparam logic [1:0] EE     = 2'b10;
`else
  localparam logic [2:0] E1_ERR = 3'd7;
  localparam logic [1:0] EE     = 2'b00;
`endif

  logic          clk = 1'b0;
  logic          rst;
  int            cyc = 0;
  int            n_checks = 0;
  int            n_fail = 0;

  logic [FW-1:0] data_in;
  logic [DW-1:0] dest_in;
  logic          tail_in, vc_in, send_in;
  logic [1:0]    credit_in;
  logic [1:0]    credit_out, credit_avail, credit_error;
  logic [FW-1:0] data_out;
  logic [DW-1:0] dest_out;
  logic          tail_out, vc_out, send_out;
  logic [5:0]    credit_count;

  logic [FW-1:0] p0_data_in, p0_data_out;
  logic [DW-1:0] p0_dest_in, p0_dest_out;
  logic          p0_tail_in, p0_vc_in, p0_send_in, p0_tail_out, p0_vc_out, p0_send_out;
  logic [1:0]    p0_credit_in, p0_credit_out, p0_credit_avail, p0_credit_error;
  logic [5:0]    p0_credit_count;

  noc_vc_pipeline_link #(.NUM_PIPELINE(P), .NUM_VC(2), .FLIT_WIDTH(FW), .DEST_WIDTH(DW),
                         .BUFFER_DEPTH(4)) u_dut (
    .clk(clk), .rst(rst), .data_in(data_in), .dest_in(dest_in), .is_tail_in(tail_in),
    .vc_in(vc_in), .send_in(send_in), .credit_out(credit_out), .data_out(data_out),
    .dest_out(dest_out), .is_tail_out(tail_out), .vc_out(vc_out), .send_out(send_out),
    .credit_in(credit_in), .credit_count(credit_count), .credit_avail(credit_avail),
    .credit_error(credit_error));

  noc_vc_pipeline_link #(.NUM_PIPELINE(0), .NUM_VC(2), .FLIT_WIDTH(FW), .DEST_WIDTH(DW),
                         .BUFFER_DEPTH(4)) u_p0 (
    .clk(clk), .rst(rst), .data_in(p0_data_in), .dest_in(p0_dest_in), .is_tail_in(p0_tail_in),
    .vc_in(p0_vc_in), .send_in(p0_send_in), .credit_out(p0_credit_out), .data_out(p0_data_out),
    .dest_out(p0_dest_out), .is_tail_out(p0_tail_out), .vc_out(p0_vc_out),
    .send_out(p0_send_out), .credit_in(p0_credit_in), .credit_count(p0_credit_count),
    .credit_avail(p0_credit_avail), .credit_error(p0_credit_error));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int         due;
    logic [FW-1:0] data;
    logic [DW-1:0] dest;
    logic       tail;
    logic       vc;
  } flit_t;
  typedef struct {
    int         due;
    logic [1:0] mask;
  } cred_t;

  flit_t fq[$];
  cred_t cq[$];
  flit_t f_mon;
  cred_t c_mon;

  // Scoreboard: outputs are matched against entries pushed when driven.
  always @(negedge clk) begin
    if (!rst) begin
      if (send_out) begin
        if (fq.size() == 0) begin
          chk("unexpected_send_out", 32'd1, 32'd0);
        end else begin
          f_mon = fq.pop_front();
          chk("send_out_cycle", cyc, f_mon.due);
          chk("data_out", 32'(data_out), 32'(f_mon.data));
          chk("dest_out", 32'(dest_out), 32'(f_mon.dest));
          chk("is_tail_out", 32'(tail_out), 32'(f_mon.tail));
          chk("vc_out", 32'(vc_out), 32'(f_mon.vc));
        end
      end
      if (fq.size() > 0 && fq[0].due < cyc) begin
        chk("missing_send_out", cyc, fq[0].due);
        void'(fq.pop_front());
      end
      if (credit_out != 2'b00) begin
        if (cq.size() == 0) begin
          chk("unexpected_credit_out", 32'(credit_out), 32'd0);
        end else begin
          c_mon = cq.pop_front();
          chk("credit_out_cycle", cyc, c_mon.due);
          chk("credit_out_mask", 32'(credit_out), 32'(c_mon.mask));
        end
      end
      if (cq.size() > 0 && cq[0].due < cyc) begin
        chk("missing_credit_out", cyc, cq[0].due);
        void'(cq.pop_front());
      end
    end
  end

  typedef struct {
    logic          send;
    logic          vc;
    logic [FW-1:0] data;
    logic          tail;
    logic [1:0]    cred;
    logic [2:0]    e0;
    logic [2:0]    e1;
    logic [1:0]    ee;
  } vec_t;
  vec_t vt[$];

  task automatic add(input logic s, input logic v, input logic [FW-1:0] d, input logic t,
                     input logic [1:0] c, input logic [2:0] e0, input logic [2:0] e1,
                     input logic [1:0] ee);
    vec_t x;
    x.send = s; x.vc = v; x.data = d; x.tail = t; x.cred = c;
    x.e0 = e0; x.e1 = e1; x.ee = ee;
    vt.push_back(x);
  endtask

  task automatic chk_track(input string tag, input logic [2:0] e0, input logic [2:0] e1,
                           input logic [1:0] ee);
    chk({tag, "_count0"}, 32'(credit_count[2:0]), 32'(e0));
    chk({tag, "_count1"}, 32'(credit_count[5:3]), 32'(e1));
    chk({tag, "_avail"}, 32'(credit_avail), {30'd0, e1 != 3'd0, e0 != 3'd0});
    chk({tag, "_error"}, 32'(credit_error), 32'(ee));
  endtask

  initial begin
    rst = 1'b1;
    {data_in, dest_in, tail_in, vc_in, send_in, credit_in} = '0;
    {p0_data_in, p0_dest_in, p0_tail_in, p0_vc_in, p0_send_in, p0_credit_in} = '0;

    // send vc data tail cred | expected count0 count1 error seen in that cycle
    add(0, 0, 16'h0000, 0, 2'b00, 4, 4, 2'b00);
    add(1, 0, 16'h0001, 0, 2'b00, 4, 4, 2'b00);
    add(1, 0, 16'h0002, 0, 2'b00, 3, 4, 2'b00);
    add(1, 0, 16'h0003, 0, 2'b00, 2, 4, 2'b00);
    add(1, 0, 16'h0004, 1, 2'b00, 1, 4, 2'b00);
    add(1, 1, 16'h00A5, 1, 2'b00, 0, 4, 2'b00);
    add(0, 0, 16'h0000, 0, 2'b01, 0, 3, 2'b00);
    add(0, 0, 16'h0000, 0, 2'b00, 0, 3, 2'b00);
    add(0, 0, 16'h0000, 0, 2'b00, 0, 3, 2'b00);
    add(0, 0, 16'h0000, 0, 2'b00, 0, 3, 2'b00);
    add(0, 0, 16'h0000, 0, 2'b01, 1, 3, 2'b00);
    add(0, 0, 16'h0000, 0, 2'b11, 1, 3, 2'b00);
    add(0, 0, 16'h0000, 0, 2'b00, 1, 3, 2'b00);
    add(0, 0, 16'h0000, 0, 2'b00, 1, 3, 2'b00);
    add(1, 0, 16'h0006, 1, 2'b00, 2, 3, 2'b00);
    add(0, 0, 16'h0000, 0, 2'b00, 2, 4, 2'b00);
    add(1, 1, 16'h0007, 0, 2'b00, 2, 4, 2'b00);
    add(1, 1, 16'h0008, 0, 2'b00, 2, 3, 2'b00);
    add(1, 1, 16'h0009, 0, 2'b00, 2, 2, 2'b00);
    add(1, 1, 16'h000A, 1, 2'b00, 2, 1, 2'b00);
    add(0, 0, 16'h0000, 0, 2'b00, 2, 0, 2'b00);
    add(1, 1, 16'h000B, 1, 2'b00, 2, 0, 2'b00);
    for (int i = 0; i < 5; i++) add(0, 0, 16'h0000, 0, 2'b00, 2, E1_ERR, EE);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_send_out", 32'(send_out), 32'd0);
    chk("rst_credit_out", 32'(credit_out), 32'd0);
    chk_track("rst", 3'd4, 3'd4, 2'b00);
    chk("rst_p0_count", 32'(p0_credit_count), 32'h24);

    foreach (vt[r]) begin
      @(posedge clk);
      #1;
      send_in = vt[r].send; vc_in = vt[r].vc; data_in = vt[r].data;
      dest_in = vt[r].data[7:0] ^ 8'hFF; tail_in = vt[r].tail; credit_in = vt[r].cred;
      if (vt[r].send) fq.push_back('{cyc + P, data_in, dest_in, tail_in, vc_in});
      if (vt[r].cred != 2'b00) cq.push_back('{cyc + P, vt[r].cred});
      @(negedge clk);
      chk_track($sformatf("row%0d", r), vt[r].e0, vt[r].e1, vt[r].ee);
    end
    chk("flit_queue_drained", 32'(fq.size()), 32'd0);
    chk("credit_queue_drained", 32'(cq.size()), 32'd0);

    // Reset with two flits and one credit still inside the pipeline.
    @(posedge clk); #1 send_in = 1'b1; vc_in = 1'b0; data_in = 16'h0BAD; credit_in = 2'b10;
    @(posedge clk); #1 data_in = 16'h0BAE; credit_in = 2'b00;
    @(posedge clk); #1 send_in = 1'b0;
    @(negedge clk);
    chk("pre_rst_count0", 32'(credit_count[2:0]), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    fq.delete(); cq.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_track("post_rst", 3'd4, 3'd4, 2'b00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_send_out", 32'(send_out), 32'd0);
      chk("post_rst_credit_out", 32'(credit_out), 32'd0);
    end

    // Zero-stage instance: outputs follow inputs within the cycle.
    @(posedge clk); #1 p0_send_in = 1'b1; p0_vc_in = 1'b0; p0_data_in = 16'h0033;
    p0_dest_in = 8'h5A; p0_tail_in = 1'b1;
    @(negedge clk);
    chk("p0_send_out", 32'(p0_send_out), 32'd1);
    chk("p0_data_out", 32'(p0_data_out), 32'h33);
    chk("p0_dest_out", 32'(p0_dest_out), 32'h5A);
    chk("p0_tail_out", 32'(p0_tail_out), 32'd1);
    chk("p0_count_same_cycle", 32'(p0_credit_count), 32'h24);
    @(posedge clk); #1 p0_send_in = 1'b0; p0_credit_in = 2'b01;
    @(negedge clk);
    chk("p0_send_out_low", 32'(p0_send_out), 32'd0);
    chk("p0_credit_out", 32'(p0_credit_out), 32'd1);
    chk("p0_count_after_send", 32'(p0_credit_count), 32'h23);
    @(posedge clk); #1 p0_credit_in = 2'b00;
    @(negedge clk);
    chk("p0_count_after_credit", 32'(p0_credit_count), 32'h24);
    chk("p0_error", 32'(p0_credit_error), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
